// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-master request bus plus single memory port bundle
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [MASK_W-1:0] m0_mask;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [MASK_W-1:0] m1_mask;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: accepts requests, drives the memory port
  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_mask,
    input  mem_rdata
  );

  // Environment side: requesters and the memory
  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_mask,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-master arbiter/sequencer for one memory port
module mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.master  bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;
  logic              pick_we;

  // State and datapath registers; reset aborts any in-flight transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Next-state: arbitrate in IDLE, latch the winner, sequence issue/wait/response
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    pick         = 1'b0;
    pick_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // Under contention the master that did not win last time goes first
          pick         = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
          pick_we      = pick ? bus.m1_we : bus.m0_we;
          sel_d        = pick;
          last_grant_d = pick;
          we_d         = pick_we;
          addr_d       = pick ? bus.m1_addr  : bus.m0_addr;
          wdata_d      = pick ? bus.m1_wdata : bus.m0_wdata;
          // Reads always fetch the full word
          mask_d       = pick_we ? (pick ? bus.m1_mask : bus.m0_mask) : '1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 4'(MEM_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          if (sel_q) rdata1_d = bus.mem_rdata;
          else       rdata0_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_mask  = mask_q;

  assign bus.m0_gnt    = (state_q == ISSUE) && !sel_q;
  assign bus.m1_gnt    = (state_q == ISSUE) &&  sel_q;
  assign bus.m0_rvalid = (state_q == RESP)  && !sel_q;
  assign bus.m1_rvalid = (state_q == RESP)  &&  sel_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifa ();
  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifb ();

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == 64'h1000) return 64'hDEADBEEF_00000013;
    return {32'hA5A5A5A5, a[31:0]};
  endfunction

  // Latency-1 memory: read data valid only in the cycle after mem_en
  always @(posedge clk) begin
    ifa.mem_rdata <= (ifa.mem_en && !ifa.mem_we) ? mem_model(ifa.mem_addr) : JUNK;
  end

  // Latency-3 memory: read data valid only in the third cycle after mem_en
  logic [2:0]  b_vld;
  logic [63:0] b_a0, b_a1;
  always @(posedge clk) begin
    b_vld         <= {b_vld[1:0], ifb.mem_en && !ifb.mem_we};
    b_a0          <= ifb.mem_addr;
    b_a1          <= b_a0;
    ifb.mem_rdata <= b_vld[1] ? mem_model(b_a1) : JUNK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    b_vld  = '0;
    reset  = 1'b1;
    ifa.m0_req = 0; ifa.m0_we = 0; ifa.m0_addr = '0; ifa.m0_wdata = '0; ifa.m0_mask = '0;
    ifa.m1_req = 0; ifa.m1_we = 0; ifa.m1_addr = '0; ifa.m1_wdata = '0; ifa.m1_mask = '0;
    ifb.m0_req = 0; ifb.m0_we = 0; ifb.m0_addr = '0; ifb.m0_wdata = '0; ifb.m0_mask = '0;
    ifb.m1_req = 0; ifb.m1_we = 0; ifb.m1_addr = '0; ifb.m1_wdata = '0; ifb.m1_mask = '0;
    repeat (3) tick();

    // Reset state
    check("rst_mem_en",   ifa.mem_en,   0);
    check("rst_mem_addr", ifa.mem_addr, 0);
    check("rst_mem_mask", ifa.mem_mask, 0);
    check("rst_gnt",      {ifa.m1_gnt, ifa.m0_gnt}, 0);
    check("rst_rdata0",   ifa.m0_rdata, 0);
    reset = 1'b0;
    tick();

    // Single read by m0; read mask must become all ones
    ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_addr = 64'h1000; ifa.m0_mask = 8'h0F;
    tick();
    check("rd_mem_en",   ifa.mem_en,   1);
    check("rd_mem_we",   ifa.mem_we,   0);
    check("rd_m0_gnt",   ifa.m0_gnt,   1);
    check("rd_m1_gnt",   ifa.m1_gnt,   0);
    check("rd_mem_mask", ifa.mem_mask, 64'hFF);
    check("rd_mem_addr", ifa.mem_addr, 64'h1000);
    ifa.m0_req = 0;
    tick();
    check("rd_wait_rv",  ifa.m0_rvalid, 0);
    check("rd_wait_en",  ifa.mem_en,    0);
    tick();
    check("rd_rvalid",   ifa.m0_rvalid, 1);
    check("rd_rdata",    ifa.m0_rdata,  64'hDEADBEEF_00000013);
    check("rd_m1_rdata", ifa.m1_rdata,  0);
    tick();
    check("rd_rv_pulse", ifa.m0_rvalid, 0);

    // Masked write by m1
    ifa.m1_req = 1; ifa.m1_we = 1; ifa.m1_addr = 64'h2004;
    ifa.m1_wdata = 64'h11223344_55667788; ifa.m1_mask = 8'hF0;
    tick();
    check("wr_mem_en",    ifa.mem_en,    1);
    check("wr_mem_we",    ifa.mem_we,    1);
    check("wr_mem_mask",  ifa.mem_mask,  64'hF0);
    check("wr_mem_addr",  ifa.mem_addr,  64'h2004);
    check("wr_mem_wdata", ifa.mem_wdata, 64'h11223344_55667788);
    check("wr_gnt",       {ifa.m1_gnt, ifa.m0_gnt}, 2'b10);
    ifa.m1_req = 0;
    tick();
    check("wr_after_en", ifa.mem_en, 0);
    check("wr_after_rv", {ifa.m1_rvalid, ifa.m0_rvalid}, 0);
    check("wr_hold_rd0", ifa.m0_rdata, 64'hDEADBEEF_00000013);
    check("wr_hold_msk", ifa.mem_mask, 64'hF0);

    // Back-to-back writes by m0, including an all-zero mask
    ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 64'h4000; ifa.m0_wdata = 64'h55; ifa.m0_mask = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b2b_en",  ifa.mem_en, (i % 2 == 0) ? 1 : 0);
      check("b2b_gnt", {ifa.m1_gnt, ifa.m0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b00);
      if (i % 2 == 0) begin
        check("b2b_addr", ifa.mem_addr, 64'h4000 + 64'(8 * (i / 2)));
        ifa.m0_addr = ifa.m0_addr + 64'h8;
      end
    end
    ifa.m0_req = 0;
    tick();

    // Reset while m1 read is in WAIT
    ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_addr = 64'h2000;
    tick();
    check("mid_gnt", ifa.m1_gnt, 1);
    ifa.m1_req = 0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_en",    ifa.mem_en,   0);
    check("mid_rst_addr",  ifa.mem_addr, 0);
    check("mid_rst_rd0",   ifa.m0_rdata, 0);
    check("mid_rst_rd1",   ifa.m1_rdata, 0);
    check("mid_rst_rv",    {ifa.m1_rvalid, ifa.m0_rvalid}, 0);
    reset = 1'b0;
    begin
      logic seen_rv;
      seen_rv = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        seen_rv = seen_rv | ifa.m0_rvalid | ifa.m1_rvalid | ifa.mem_en;
      end
      check("mid_no_rv", seen_rv, 0);
    end

    // Continuous contention: grants alternate starting with m0
    ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_addr = 64'h100;
    ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_addr = 64'h200;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        if (ifa.m0_gnt || ifa.m1_gnt) break;
      end
      check("cont_gnt", {ifa.m1_gnt, ifa.m0_gnt}, (t % 2 == 0) ? 2'b01 : 2'b10);
      if (t == 3) begin
        ifa.m0_req = 0;
        ifa.m1_req = 0;
      end
      for (int k = 0; k < 8; k++) begin
        tick();
        if (ifa.m0_rvalid || ifa.m1_rvalid) break;
      end
      check("cont_rv", {ifa.m1_rvalid, ifa.m0_rvalid}, (t % 2 == 0) ? 2'b01 : 2'b10);
      if (t % 2 == 0) check("cont_rd0", ifa.m0_rdata, 64'hA5A5A5A5_00000100);
      else            check("cont_rd1", ifa.m1_rdata, 64'hA5A5A5A5_00000200);
      if (t == 0) check("cont_rd1_untouched", ifa.m1_rdata, 0);
    end
    tick();

    // Latency 3: gnt one cycle after sampling, rvalid five cycles after
    ifb.m0_req = 1; ifb.m0_we = 0; ifb.m0_addr = 64'h3000;
    tick();
    check("lat3_gnt", ifb.m0_gnt, 1);
    ifb.m0_req = 0;
    for (int c = 2; c < 5; c++) begin
      tick();
      check("lat3_early_rv", ifb.m0_rvalid, 0);
    end
    tick();
    check("lat3_rv",    ifb.m0_rvalid, 1);
    check("lat3_rdata", ifb.m0_rdata,  64'hA5A5A5A5_00003000);
    tick();
    check("lat3_rv_end", ifb.m0_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter and sequencer for the single 64-bit SoC memory port.
- Master 0 is the CPU core (instruction fetch, load and store). Master 1 is a secondary requester such as a DMA or boot loader.
- Serialises requests with round-robin priority and drives the memory address, write data, byte mask and enable.
- Returns read data with a fixed latency. At most one transaction is outstanding at any time.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; the byte mask is DATA_W/8 bits wide.
- MEM_LATENCY, 1, cycles from the mem_en cycle until mem_rdata is valid; legal range 1 to 15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_gnt is sampled high.
- m0_we  in  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_mask  in  DATA_W/8  master 0 byte-lane write mask.
- m0_gnt  out  1  one-cycle pulse: master 0 request accepted and issued.
- m0_rvalid  out  1  one-cycle pulse: m0_rdata is valid.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_gnt, m1_rvalid, m1_rdata: identical to the m0_* ports, for master 1.
- mem_en  out  1  memory access strobe, high for one cycle per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_mask  out  DATA_W/8  memory byte mask.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant = 1, so master 0 wins the first contention.
- IDLE:
  - Samples m0_req and m1_req.
  - Only one request high: that master is selected.
  - Both high: the master other than last_grant is selected.
  - Neither high: remain in IDLE.
  - On selection: latch that master's we, addr, wdata and mask plus the master index; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_en = 1 and mem_we = latched we.
  - mem_addr and mem_wdata = latched values, passed unmodified (no alignment).
  - mem_mask = latched mask for writes, all ones for reads.
  - mx_gnt = 1 for the selected master only.
  - Write: go to IDLE. A write occupies 2 cycles; a back-to-back write is issued 2 cycles later.
  - Read: go to WAIT with a counter loaded to MEM_LATENCY.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, mem_rdata is captured into mx_rdata of the selected master at the clock edge; go to RESP.
- RESP: mx_rvalid = 1 for one cycle, then go to IDLE.
- Read latency: IDLE sample cycle to rvalid cycle is MEM_LATENCY+2 cycles. With the default of 1, req sampled at cycle 0 gives gnt in cycle 1 and rvalid in cycle 3.
- Memory outputs: mem_en and mem_we are 0 outside ISSUE. mem_addr, mem_wdata and mem_mask hold their last values.
- Read data: mx_rdata holds its value until that master's next read completes. The other master's rdata is never modified.
- Request handling:
  - A request still high after gnt is treated as a new request at the next IDLE.
  - Requests are ignored outside IDLE.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A lone requester is granted every transaction.
- Write with an all-zero mask: still issued (mem_en = 1); the master still receives gnt.
- Reset asserted in any state:
  - Next cycle: state IDLE; all outputs 0 including rdata; last_grant = 1.
  - The in-flight transaction is aborted and its gnt or rvalid is never produced.

Test Plan:
- Single read: m0 reads addr 0x1000; memory model returns 0xDEADBEEF_00000013 with latency 1 → mem_en in cycle 1 with mask 0xFF and m0_gnt in the same cycle; m0_rvalid in cycle 3 with that data; m1_rdata stays 0.
- Masked write: m1 writes 0x11223344_55667788 to 0x2004 with mask 0xF0 → one ISSUE cycle with mem_we = 1, mem_mask = 0xF0; m1_gnt pulses; no rvalid; state back to IDLE next cycle.
- Contention: both masters hold read requests from reset for 4 transactions → grant order 0,1,0,1; each master's rdata matches its own address in the memory model.
- Latency sweep: MEM_LATENCY = 3 → rvalid exactly 5 cycles after the request is sampled; data captured from mem_rdata in the final WAIT cycle.
- Reset mid-read: assert reset in WAIT → no rvalid ever appears; all outputs 0 next cycle; the following contention is granted to m0.
- Back-to-back writes from m0 with m1 idle → mem_en on alternating cycles; every write granted to m0.
